// File: rtl/quadrant_mapper_pkg.sv
// Shared types and constants for the quadrant mapper: quarter codes, midscale helper
// and saturation counter width.
package quadrant_mapper_pkg;

    typedef enum logic [1:0] {
        Q_PP = 2'b00,
        Q_NP = 2'b01,
        Q_NN = 2'b10,
        Q_PN = 2'b11
    } quarter_t;

    localparam int SAT_CNT_W = 16;

    function automatic int mid_of(input int width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/qm_fold_sat.sv
// One axis of the output stage: applies the quarter sign, adds midscale and clamps
// the result into the unsigned offset-binary range.
module qm_fold_sat
    import quadrant_mapper_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic signed [DATA_WIDTH:0]   operand,
    input  logic                         negate,
    output logic        [DATA_WIDTH-1:0] result,
    output logic                         clamped
);

    // Two extra bits cover MID +/- the full signed operand range without overflow.
    localparam int EW = DATA_WIDTH + 2;
    localparam logic signed [EW-1:0] MID = EW'(mid_of(DATA_WIDTH));
    localparam logic signed [EW-1:0] TOP = EW'((1 << DATA_WIDTH) - 1);

    logic signed [EW-1:0] operand_ext;
    logic signed [EW-1:0] sum;

    always_comb begin
        operand_ext = {operand[DATA_WIDTH], operand};
        sum         = negate ? (MID - operand_ext) : (MID + operand_ext);
        result      = sum[DATA_WIDTH-1:0];
        clamped     = 1'b0;
        if (sum < 0) begin
            result  = '0;
            clamped = 1'b1;
        end else if (sum > TOP) begin
            result  = '1;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/quadrant_mapper.sv
// Two-stage valid/ready output stage folding CORDIC x/y back to the full circle as
// clamped offset-binary. QUADRANT_MAPPER_STATS_EN builds the saturated-beat counter.
module quadrant_mapper
    import quadrant_mapper_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int TAG_WIDTH   = 4,
    parameter int OCTANT_MODE = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [1:0]                  s_quarter,
    input  logic                        s_swap,
    input  logic signed [DATA_WIDTH:0]  s_x,
    input  logic signed [DATA_WIDTH:0]  s_y,
    input  logic [TAG_WIDTH-1:0]        s_tag,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_x,
    output logic [DATA_WIDTH-1:0]       m_y,
    output logic [TAG_WIDTH-1:0]        m_tag,
    output logic [1:0]                  m_sat,
    output logic [SAT_CNT_W-1:0]        sat_count
);

    logic                       v1;
    logic signed [DATA_WIDTH:0] a1;
    logic signed [DATA_WIDTH:0] b1;
    quarter_t                   q1;
    logic [TAG_WIDTH-1:0]       tag1;
    logic                       v2;
    logic                       advance2;
    logic                       swap_en;
    logic                       neg_x;
    logic                       neg_y;
    logic [DATA_WIDTH-1:0]      fold_x;
    logic [DATA_WIDTH-1:0]      fold_y;
    logic                       clamp_x;
    logic                       clamp_y;

    assign advance2 = !v2 || m_ready;
    assign s_ready  = !v1 || advance2;
    assign m_valid  = v2;
    assign swap_en  = (OCTANT_MODE != 0) && s_swap;

    always_ff @(posedge clock) begin
        if (reset) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            q1   <= Q_PP;
            tag1 <= '0;
        end else if (s_ready) begin
            v1 <= s_valid;
            if (s_valid) begin
                a1   <= swap_en ? s_y : s_x;
                b1   <= swap_en ? s_x : s_y;
                q1   <= quarter_t'(s_quarter);
                tag1 <= s_tag;
            end
        end
    end

    // X is negated in the left half-plane, Y in the lower half-plane.
    assign neg_x = (q1 == Q_NP) || (q1 == Q_NN);
    assign neg_y = (q1 == Q_NN) || (q1 == Q_PN);

    qm_fold_sat #(.DATA_WIDTH(DATA_WIDTH)) fold_x_inst (
        .operand (a1),
        .negate  (neg_x),
        .result  (fold_x),
        .clamped (clamp_x)
    );

    qm_fold_sat #(.DATA_WIDTH(DATA_WIDTH)) fold_y_inst (
        .operand (b1),
        .negate  (neg_y),
        .result  (fold_y),
        .clamped (clamp_y)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            v2    <= 1'b0;
            m_x   <= '0;
            m_y   <= '0;
            m_tag <= '0;
            m_sat <= '0;
        end else if (advance2) begin
            v2 <= v1;
            if (v1) begin
                m_x   <= fold_x;
                m_y   <= fold_y;
                m_tag <= tag1;
                m_sat <= {clamp_y, clamp_x};
            end
        end
    end

`ifdef QUADRANT_MAPPER_STATS_EN
    logic [SAT_CNT_W-1:0] sat_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (v2 && m_ready && (m_sat != 2'b00) && (sat_cnt != '1)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

    assign sat_count = sat_cnt;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_quadrant_mapper.sv
// Randomised and directed bench for quadrant_mapper; runs OCTANT_MODE=0 and =1 copies
// side by side against a queue-based behavioural model.
module tb_quadrant_mapper;
    import quadrant_mapper_pkg::*;

    localparam int DW   = 12;
    localparam int TW   = 4;
    localparam int MID  = 2048;
    localparam int MAXV = 4095;
`ifdef QUADRANT_MAPPER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [DW:0]   x;
        logic [DW:0]   y;
        logic [1:0]    q;
        logic          swap;
        logic [TW-1:0] tag;
        int            cyc;
    } beat_t;

    logic          clock;
    logic          reset;
    logic          s_valid;
    logic [1:0]    s_quarter;
    logic          s_swap;
    logic [DW:0]   s_x;
    logic [DW:0]   s_y;
    logic [TW-1:0] s_tag;
    logic          m_ready;

    logic          s_ready_a, s_ready_b;
    logic          m_valid_a, m_valid_b;
    logic [DW-1:0] m_x_a, m_x_b, m_y_a, m_y_b;
    logic [TW-1:0] m_tag_a, m_tag_b;
    logic [1:0]    m_sat_a, m_sat_b;
    logic [15:0]   sat_count_a, sat_count_b;

    beat_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    cycle = 0;
    int    exp_cnt_a = 0;
    int    exp_cnt_b = 0;
    bit    chk_lat = 1'b0;
    logic  acc;

    quadrant_mapper #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OCTANT_MODE(0)) dut_a (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_quarter(s_quarter), .s_swap(s_swap), .s_x(s_x), .s_y(s_y), .s_tag(s_tag),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_x(m_x_a), .m_y(m_y_a),
        .m_tag(m_tag_a), .m_sat(m_sat_a), .sat_count(sat_count_a)
    );

    quadrant_mapper #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OCTANT_MODE(1)) dut_b (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_quarter(s_quarter), .s_swap(s_swap), .s_x(s_x), .s_y(s_y), .s_tag(s_tag),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_x(m_x_b), .m_y(m_y_b),
        .m_tag(m_tag_b), .m_sat(m_sat_b), .sat_count(sat_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)",
                     name, observed, expected, cycle);
        end
    endtask

    // Returns {sat_y, sat_x, Y, X} computed with plain integer arithmetic.
    function automatic logic [25:0] refBeat(input beat_t bt, input bit octant);
        int xi, yi, a, b, xv, yv;
        logic sx, sy;
        xi = int'($signed(bt.x));
        yi = int'($signed(bt.y));
        a  = (octant && bt.swap) ? yi : xi;
        b  = (octant && bt.swap) ? xi : yi;
        xv = (bt.q == 2'd1 || bt.q == 2'd2) ? MID - a : MID + a;
        yv = (bt.q >= 2'd2) ? MID - b : MID + b;
        sx = (xv < 0) || (xv > MAXV);
        sy = (yv < 0) || (yv > MAXV);
        if (xv < 0) xv = 0;
        if (xv > MAXV) xv = MAXV;
        if (yv < 0) yv = 0;
        if (yv > MAXV) yv = MAXV;
        return {sy, sx, 12'(yv), 12'(xv)};
    endfunction

    task automatic applyStimulus(input logic v, input logic [DW:0] x, input logic [DW:0] y,
                                 input logic [1:0] q, input logic sw, input logic [TW-1:0] tag,
                                 input logic mr, output logic accepted);
        logic        exp_ready;
        logic        exp_mvalid;
        logic [25:0] ra, rb;
        beat_t       bt;
        @(negedge clock);
        checkOutput("sat_count_a", 32'(sat_count_a), STATS ? exp_cnt_a : 0);
        checkOutput("sat_count_b", 32'(sat_count_b), STATS ? exp_cnt_b : 0);
        s_valid = v; s_x = x; s_y = y; s_quarter = q; s_swap = sw; s_tag = tag; m_ready = mr;
        #1;
        exp_ready  = (sb.size() < 2) || mr;
        exp_mvalid = (sb.size() > 0) && (sb[0].cyc <= cycle - 2);
        checkOutput("s_ready_a", 32'(s_ready_a), 32'(exp_ready));
        checkOutput("s_ready_b", 32'(s_ready_b), 32'(exp_ready));
        checkOutput("m_valid_a", 32'(m_valid_a), 32'(exp_mvalid));
        checkOutput("m_valid_b", 32'(m_valid_b), 32'(exp_mvalid));
        if (exp_mvalid) begin
            ra = refBeat(sb[0], 1'b0);
            rb = refBeat(sb[0], 1'b1);
            checkOutput("m_x_a", 32'(m_x_a), 32'(ra[11:0]));
            checkOutput("m_y_a", 32'(m_y_a), 32'(ra[23:12]));
            checkOutput("m_sat_a", 32'(m_sat_a), 32'(ra[25:24]));
            checkOutput("m_tag_a", 32'(m_tag_a), 32'(sb[0].tag));
            checkOutput("m_x_b", 32'(m_x_b), 32'(rb[11:0]));
            checkOutput("m_y_b", 32'(m_y_b), 32'(rb[23:12]));
            checkOutput("m_sat_b", 32'(m_sat_b), 32'(rb[25:24]));
            checkOutput("m_tag_b", 32'(m_tag_b), 32'(sb[0].tag));
            if (mr) begin
                if (chk_lat) checkOutput("latency", 32'(cycle - sb[0].cyc), 32'd2);
                if (ra[25:24] != 2'b00 && exp_cnt_a != 16'hFFFF) exp_cnt_a++;
                if (rb[25:24] != 2'b00 && exp_cnt_b != 16'hFFFF) exp_cnt_b++;
                void'(sb.pop_front());
            end
        end
        accepted = v && exp_ready;
        if (accepted) begin
            bt.x = x; bt.y = y; bt.q = q; bt.swap = sw; bt.tag = tag; bt.cyc = cycle;
            sb.push_back(bt);
        end
        cycle++;
    endtask

    task automatic doReset(input int n);
        repeat (n) begin
            @(negedge clock);
            reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
            cycle++;
        end
        @(negedge clock);
        reset = 1'b0;
        cycle++;
        sb.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
        #1;
        checkOutput("rst_m_valid_a", 32'(m_valid_a), 0);
        checkOutput("rst_m_valid_b", 32'(m_valid_b), 0);
        checkOutput("rst_s_ready", 32'(s_ready_a), 1);
        checkOutput("rst_m_x", 32'(m_x_a), 0);
        checkOutput("rst_m_y", 32'(m_y_b), 0);
        checkOutput("rst_m_tag", 32'(m_tag_a), 0);
        checkOutput("rst_m_sat", 32'(m_sat_b), 0);
        checkOutput("rst_sat_count", 32'(sat_count_a), 0);
    endtask

    task automatic drain(input int n);
        logic a;
        repeat (n) applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, '0, 1'b1, a);
        checkOutput("drain_empty", 32'(sb.size()), 0);
    endtask

    function automatic logic [DW:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 13'h0FFF;
            1:       return 13'h1000;
            default: return 13'($urandom);
        endcase
    endfunction

    logic [DW:0] dir_x [6] = '{13'h100, 13'h100, 13'h0FFF, 13'h0FFF, 13'h010, 13'h1000};
    logic [DW:0] dir_y [6] = '{13'h200, 13'h200, 13'h000, 13'h000, 13'h020, 13'h1000};
    logic [1:0]  dir_q [6] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
    logic        dir_s [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int idx;
        reset = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; s_quarter = '0;
        s_swap = 1'b0; s_tag = '0; m_ready = 1'b0;
        doReset(2);

        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, dir_x[i], dir_y[i], dir_q[i], dir_s[i], 4'(i + 1), 1'b1, acc);
        drain(4);

        for (int i = 0; i < 16; i++)
            applyStimulus(1'b1, randOperand(), randOperand(), 2'($urandom), 1'($urandom),
                          4'(i), 1'b1, acc);
        drain(4);
        chk_lat = 1'b0;

        idx = 0;
        for (int step = 0; step < 20; step++) begin
            if (idx < 4) begin
                applyStimulus(1'b1, 13'(idx * 64), 13'(idx * 32), 2'(idx), 1'b0,
                              4'(idx + 1), step >= 6, acc);
                if (acc) idx++;
            end
        end
        checkOutput("bp_all_accepted", 32'(idx), 32'd4);
        drain(6);

        applyStimulus(1'b1, 13'h055, 13'h0AA, 2'd1, 1'b0, 4'hA, 1'b0, acc);
        applyStimulus(1'b1, 13'h0FFF, 13'h1000, 2'd2, 1'b0, 4'hB, 1'b0, acc);
        doReset(1);
        repeat (4) applyStimulus(1'b0, '0, '0, 2'd0, 1'b0, '0, 1'b1, acc);

        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 9) < 7, randOperand(), randOperand(),
                          2'($urandom), 1'($urandom), 4'($urandom),
                          $urandom_range(0, 9) < 7, acc);
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
